// File: rtl/sanduba_panel_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : sanduba_panel_if                                             |
// | Description : Request/response bundle between the front panel and the      |
// |               sandwich vending FSM.                                        |
// |               master (panel) drives R_green, R_atum, R_bacon, M100, DEV,   |
// |               erro; slave (FSM) drives busy, D100, GREEN, ATUM, BACON.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sanduba_panel_if;
  logic busy;
  logic D100;
  logic GREEN;
  logic ATUM;
  logic BACON;
  logic R_green;
  logic R_atum;
  logic R_bacon;
  logic M100;
  logic DEV;
  logic erro;

  modport master (
    input  busy, D100, GREEN, ATUM, BACON,
    output R_green, R_atum, R_bacon, M100, DEV, erro
  );

  modport slave (
    output busy, D100, GREEN, ATUM, BACON,
    input  R_green, R_atum, R_bacon, M100, DEV, erro
  );
endinterface
`default_nettype wire

// File: rtl/sanduba_panel.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : sanduba_panel                                                |
// | Description : Front-panel request issuer. Synchronizes and debounces the   |
// |               raw buttons/coin sensor, latches presses as pending events   |
// |               and issues them to the vending FSM as one-cycle pulses while |
// |               the FSM is not busy. Counts deliveries/coin returns and      |
// |               flags protocol timeouts.                                     |
// | Ports       : clock, reset (async, active low)                             |
// |               btn_green/btn_atum/btn_bacon/coin_in/btn_dev : raw inputs    |
// |               bus          : FSM handshake (master side)                   |
// |               pending      : latched unissued {dev,coin,bacon,atum,green}  |
// |               *_cnt        : saturating delivery / coin-return counters    |
// |               timeout_err  : sticky protocol-timeout flag                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sanduba_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int ACK_WAIT        = 3,
  parameter int DONE_TIMEOUT    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_green,
  input  logic               btn_atum,
  input  logic               btn_bacon,
  input  logic               coin_in,
  input  logic               btn_dev,
  sanduba_panel_if.master    bus,
  output logic [4:0]         pending,
  output logic [CNT_W-1:0]   green_cnt,
  output logic [CNT_W-1:0]   atum_cnt,
  output logic [CNT_W-1:0]   bacon_cnt,
  output logic [CNT_W-1:0]   coin_ret_cnt,
  output logic               timeout_err
);

  localparam int c_DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_WAIT_MAX = (ACK_WAIT > DONE_TIMEOUT) ? ACK_WAIT : DONE_TIMEOUT;
  localparam int c_WT_W     = $clog2(c_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Bit order shared by pending and the request vector.
  logic [4:0] w_raw;
  assign w_raw = {btn_dev, coin_in, btn_bacon, btn_atum, btn_green};

  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The event flop fires on the same edge the counter reaches its ceiling, so
  // the pulse is high exactly during the cycle the count first equals it.
  for (genvar i = 0; i < 5; i++) begin : g_debounce
    logic [c_DB_W-1:0] r_db_cnt;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_db_cnt <= '0;
        r_evt[i] <= 1'b0;
      end else begin
        r_evt[i] <= r_sync2[i] && (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1));
        if (!r_sync2[i])
          r_db_cnt <= '0;
        else if (r_db_cnt != c_DB_W'(DEBOUNCE_CYCLES))
          r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_req;
  logic [4:0]        w_req_nxt;
  logic              r_erro;
  logic              w_erro_nxt;
  logic [c_WT_W-1:0] r_wait;
  logic [c_WT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_to_set;
  logic [4:0]        r_pending;
  logic [4:0]        w_clr;
  logic              w_multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = (r_pending & (r_pending - 5'd1)) != 5'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_req     <= '0;
      r_erro    <= 1'b0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_erro    <= w_erro_nxt;
      r_wait    <= w_wait_nxt;
      if (w_to_set)
        r_timeout <= 1'b1;
      // Events landing during ISSUE survive even if their bit is being issued.
      r_pending <= (r_pending & ~w_clr) | r_evt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = '0;
    w_erro_nxt  = 1'b0;
    w_wait_nxt  = r_wait;
    w_to_set    = 1'b0;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        if ((r_pending != 5'd0) && !bus.busy) begin
          w_state_nxt = S_ISSUE;
          w_req_nxt   = r_pending;
          w_erro_nxt  = w_multi;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_BUSY;
        w_clr       = r_req;
        w_wait_nxt  = '0;
      end
      S_WAIT_BUSY: begin
        if (bus.busy) begin
          w_state_nxt = S_WAIT_DONE;
          w_wait_nxt  = '0;
        end else if (r_wait == c_WT_W'(ACK_WAIT - 1)) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt  = r_wait + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.busy) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait < c_WT_W'(DONE_TIMEOUT)) begin
          w_wait_nxt = r_wait + 1'b1;
          if (r_wait == c_WT_W'(DONE_TIMEOUT - 1))
            w_to_set = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Requests are masked by busy so a pulse can never overlap an FSM episode,
  // even if another source raises busy during the issue cycle.
  assign bus.R_green = r_req[0] & ~bus.busy;
  assign bus.R_atum  = r_req[1] & ~bus.busy;
  assign bus.R_bacon = r_req[2] & ~bus.busy;
  assign bus.M100    = r_req[3] & ~bus.busy;
  assign bus.DEV     = r_req[4] & ~bus.busy;
  assign bus.erro    = r_erro   & ~bus.busy;

  assign pending     = r_pending;
  assign timeout_err = r_timeout;

  // Counter order: green, atum, bacon, coin return.
  logic [3:0]       w_strb;
  logic [3:0]       r_strb_prev;
  logic [CNT_W-1:0] r_cnt [4];

  assign w_strb = {bus.D100, bus.BACON, bus.ATUM, bus.GREEN};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_strb_prev <= '0;
    else
      r_strb_prev <= w_strb;
  end

  for (genvar j = 0; j < 4; j++) begin : g_counter
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)
        r_cnt[j] <= '0;
      else if (w_strb[j] && !r_strb_prev[j] && (r_cnt[j] != {CNT_W{1'b1}}))
        r_cnt[j] <= r_cnt[j] + 1'b1;
    end
  end

  assign green_cnt    = r_cnt[0];
  assign atum_cnt     = r_cnt[1];
  assign bacon_cnt    = r_cnt[2];
  assign coin_ret_cnt = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_sanduba_panel.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_sanduba_panel                                             |
// | Description : Self-checking bench for sanduba_panel. Expected request      |
// |               timing is derived from the press time plus fixed latency,    |
// |               counters from counted strobe rising edges.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sanduba_panel;

  localparam int DB = 4;
  localparam int AW = 3;
  localparam int DT = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn_v = '0;
  logic       busy_s = 1'b0;
  logic [3:0] strb_v = '0;

  always #5 clock = ~clock;

  sanduba_panel_if u_bus ();
  sanduba_panel_if u_bus_w2 ();

  assign u_bus.busy     = busy_s;
  assign u_bus.GREEN    = strb_v[0];
  assign u_bus.ATUM     = strb_v[1];
  assign u_bus.BACON    = strb_v[2];
  assign u_bus.D100     = strb_v[3];
  assign u_bus_w2.busy  = busy_s;
  assign u_bus_w2.GREEN = strb_v[0];
  assign u_bus_w2.ATUM  = strb_v[1];
  assign u_bus_w2.BACON = strb_v[2];
  assign u_bus_w2.D100  = strb_v[3];

  logic [4:0] pending, pending_w2;
  logic [7:0] green_cnt, atum_cnt, bacon_cnt, coin_ret_cnt;
  logic [1:0] green_cnt_w2, atum_cnt_w2, bacon_cnt_w2, coin_ret_cnt_w2;
  logic       timeout_err, timeout_err_w2;

  sanduba_panel #(.DEBOUNCE_CYCLES(DB), .CNT_W(8), .ACK_WAIT(AW), .DONE_TIMEOUT(DT)) u_dut (
    .clock(clock), .reset(reset),
    .btn_green(btn_v[0]), .btn_atum(btn_v[1]), .btn_bacon(btn_v[2]),
    .coin_in(btn_v[3]), .btn_dev(btn_v[4]),
    .bus(u_bus.master), .pending(pending),
    .green_cnt(green_cnt), .atum_cnt(atum_cnt), .bacon_cnt(bacon_cnt),
    .coin_ret_cnt(coin_ret_cnt), .timeout_err(timeout_err)
  );

  sanduba_panel #(.DEBOUNCE_CYCLES(DB), .CNT_W(2), .ACK_WAIT(AW), .DONE_TIMEOUT(DT)) u_dut_w2 (
    .clock(clock), .reset(reset),
    .btn_green(btn_v[0]), .btn_atum(btn_v[1]), .btn_bacon(btn_v[2]),
    .coin_in(btn_v[3]), .btn_dev(btn_v[4]),
    .bus(u_bus_w2.master), .pending(pending_w2),
    .green_cnt(green_cnt_w2), .atum_cnt(atum_cnt_w2), .bacon_cnt(bacon_cnt_w2),
    .coin_ret_cnt(coin_ret_cnt_w2), .timeout_err(timeout_err_w2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Cycle index: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [4:0] req;
  assign req = {u_bus.DEV, u_bus.M100, u_bus.R_bacon, u_bus.R_atum, u_bus.R_green};

  typedef struct {
    int         c;
    logic [4:0] v;
    logic       e;
  } rec_t;
  rec_t log_q[$];

  always @(negedge clock) begin
    if ((req != 5'd0) || u_bus.erro) begin
      log_q.push_back('{cyc, req, u_bus.erro});
      chk("req_during_busy", {27'd0, req & {5{busy_s}}}, 32'd0);
    end
  end

  // FSM stand-in: answers each request with busy after resp_ack extra cycles.
  bit resp_en   = 1'b0;
  int resp_ack  = 0;
  int resp_len  = 3;
  initial begin
    forever begin
      @(negedge clock);
      if (resp_en && (req != 5'd0)) begin
        repeat (resp_ack + 1) @(posedge clock);
        #1 busy_s = 1'b1;
        repeat (resp_len) @(posedge clock);
        #1 busy_s = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Raw level first sampled at edge t_first, sampled high for 'hold' edges.
  task automatic press(input logic [4:0] m, input int hold, output int t_first);
    tick();
    btn_v   = btn_v | m;
    t_first = cyc + 1;
    repeat (hold) tick();
    btn_v = btn_v & ~m;
  endtask

  task automatic wait_req(output rec_t r, output bit ok);
    int k;
    k = 0;
    while ((log_q.size() == 0) && (k < 40)) begin
      @(negedge clock);
      #1;
      k++;
    end
    ok = (log_q.size() != 0);
    if (ok) begin
      r = log_q.pop_front();
    end else begin
      r = '{0, 5'd0, 1'b0};
      chk("req_seen", 32'd0, 32'd1);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_req"},     {27'd0, req}, 32'd0);
    chk({tag, "_erro"},    {31'd0, u_bus.erro}, 32'd0);
    chk({tag, "_pending"}, {27'd0, pending}, 32'd0);
    chk({tag, "_cnts"},    {green_cnt, atum_cnt, bacon_cnt, coin_ret_cnt}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
  endtask

  int cnt_model[4];
  logic [3:0] strb_prev = '0;

  task automatic strobe_step(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i] && !strb_prev[i]) cnt_model[i]++;
    strb_prev = v;
    strb_v    = v;
    tick();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_green"}, {24'd0, green_cnt},    (cnt_model[0] > 255) ? 255 : cnt_model[0]);
    chk({tag, "_atum"},  {24'd0, atum_cnt},     (cnt_model[1] > 255) ? 255 : cnt_model[1]);
    chk({tag, "_bacon"}, {24'd0, bacon_cnt},    (cnt_model[2] > 255) ? 255 : cnt_model[2]);
    chk({tag, "_coin"},  {24'd0, coin_ret_cnt}, (cnt_model[3] > 255) ? 255 : cnt_model[3]);
    chk({tag, "_green_w2"}, {30'd0, green_cnt_w2},    (cnt_model[0] > 3) ? 3 : cnt_model[0]);
    chk({tag, "_atum_w2"},  {30'd0, atum_cnt_w2},     (cnt_model[1] > 3) ? 3 : cnt_model[1]);
    chk({tag, "_bacon_w2"}, {30'd0, bacon_cnt_w2},    (cnt_model[2] > 3) ? 3 : cnt_model[2]);
    chk({tag, "_coin_w2"},  {30'd0, coin_ret_cnt_w2}, (cnt_model[3] > 3) ? 3 : cnt_model[3]);
  endtask

  // One press, answered by the stand-in FSM, checked against expected timing.
  task automatic press_and_check(input string tag, input logic [4:0] m, input int hold);
    int   t;
    rec_t r;
    bit   ok;
    resp_en  = 1'b1;
    resp_ack = $urandom_range(0, AW - 1);
    resp_len = $urandom_range(1, 8);
    press(m, hold, t);
    wait_req(r, ok);
    if (ok) begin
      chk({tag, "_cycle"}, r.c, t + DB + 3);
      chk({tag, "_vec"},   {27'd0, r.v}, {27'd0, m});
      chk({tag, "_erro"},  {31'd0, r.e}, ($countones(m) > 1) ? 32'd1 : 32'd0);
    end
    repeat (20) tick();
    chk({tag, "_single"},  log_q.size(), 32'd0);
    chk({tag, "_pending"}, {27'd0, pending}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
    log_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int   t;
    int   b;
    rec_t r;
    bit   ok;
    logic [4:0] m;

    repeat (3) tick();
    check_idle_zero("reset");
    reset = 1'b1;
    repeat (3) tick();

    // Coin held for 10 cycles: one M100 pulse, 7 cycles after first sample.
    press_and_check("coin_hold", 5'b01000, 10);

    // Simultaneous tuna + refund: both requests together with erro.
    press_and_check("atum_dev", 5'b10010, DB);

    // Random subsets and hold lengths.
    for (int i = 0; i < 8; i++) begin
      m = 5'($urandom_range(1, 31));
      press_and_check("rand_press", m, $urandom_range(DB, DB + 3));
    end

    // Glitches shorter than the debounce window produce nothing.
    for (int i = 0; i < 3; i++) begin
      m = 5'($urandom_range(1, 31));
      press(m, $urandom_range(1, DB - 1), t);
      repeat (15) tick();
      chk("glitch_noreq",   log_q.size(), 32'd0);
      chk("glitch_pending", {27'd0, pending}, 32'd0);
    end

    // Press while the FSM is busy: held in pending, issued once busy falls.
    resp_en = 1'b0;
    tick();
    busy_s = 1'b1;
    b = cyc;
    press(5'b00001, 6, t);
    repeat (8) tick();
    chk("busy_hold_pending", {27'd0, pending}, 32'd1);
    chk("busy_hold_noreq",   log_q.size(), 32'd0);
    while (cyc < b + 20) tick();
    chk("busy_end_pending", {27'd0, pending}, 32'd1);
    busy_s = 1'b0;
    b = cyc;
    wait_req(r, ok);
    if (ok) begin
      chk("busy_release_cycle", r.c, b + 1);
      chk("busy_release_vec",   {27'd0, r.v}, 32'd1);
      chk("busy_release_erro",  {31'd0, r.e}, 32'd0);
    end
    tick();
    busy_s = 1'b1;
    repeat (3) tick();
    busy_s = 1'b0;
    repeat (5) tick();
    chk("busy_release_single",  log_q.size(), 32'd0);
    chk("busy_release_pending", {27'd0, pending}, 32'd0);
    chk("busy_release_timeout", {31'd0, timeout_err}, 32'd0);

    // Busy never rises: timeout after ACK_WAIT cycles, then back to idle.
    press(5'b00001, DB, t);
    wait_req(r, ok);
    if (ok) begin
      goto_cycle(r.c + AW);
      chk("ack_to_before", {31'd0, timeout_err}, 32'd0);
      goto_cycle(r.c + AW + 1);
      chk("ack_to_set", {31'd0, timeout_err}, 32'd1);
    end
    log_q.delete();
    press_and_check_sticky: begin
      resp_en  = 1'b1;
      resp_ack = 0;
      resp_len = 2;
      press(5'b00010, DB, t);
      wait_req(r, ok);
      if (ok) chk("after_ack_to_cycle", r.c, t + DB + 3);
      repeat (12) tick();
      chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
      log_q.delete();
    end

    // Reset clears the sticky flag.
    resp_en = 1'b0;
    reset   = 1'b0;
    tick();
    check_idle_zero("reset2");
    reset = 1'b1;
    repeat (3) tick();

    // Busy stuck high: timeout after DONE_TIMEOUT busy cycles, then reset mid-wait.
    press(5'b00001, DB, t);
    wait_req(r, ok);
    if (ok) begin
      @(posedge clock);
      #1 busy_s = 1'b1;
      goto_cycle(r.c + 2 + DT - 1);
      chk("done_to_before", {31'd0, timeout_err}, 32'd0);
      goto_cycle(r.c + 2 + DT);
      chk("done_to_set", {31'd0, timeout_err}, 32'd1);
      press(5'b00100, DB, t);
      repeat (3) tick();
      chk("done_wait_pending", {27'd0, pending}, 32'd4);
      goto_cycle(r.c + 2 + 40);
      #3 reset = 1'b0;
      #1;
      check_idle_zero("async_reset");
      busy_s = 1'b0;
    end
    tick();
    reset = 1'b1;
    repeat (15) tick();
    chk("post_reset_noreq",   log_q.size(), 32'd0);
    chk("post_reset_pending", {27'd0, pending}, 32'd0);
    chk("post_reset_timeout", {31'd0, timeout_err}, 32'd0);

    // Counters: 3 GREEN pulses and D100 held 5 cycles.
    for (int i = 0; i < 4; i++) cnt_model[i] = 0;
    for (int i = 0; i < 3; i++) begin
      strobe_step(4'b0001);
      strobe_step(4'b0000);
    end
    for (int i = 0; i < 5; i++) strobe_step(4'b1000);
    strobe_step(4'b0000);
    tick();
    check_counters("cnt_directed");
    // Two more GREEN pulses: 5 total saturates the 2-bit counter at 3.
    for (int i = 0; i < 2; i++) begin
      strobe_step(4'b0001);
      strobe_step(4'b0000);
    end
    tick();
    check_counters("cnt_five");
    // Random strobe traffic.
    for (int i = 0; i < 200; i++) strobe_step(4'($urandom_range(0, 15)));
    strobe_step(4'b0000);
    tick();
    check_counters("cnt_random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sanduba_panel.md
Name: sanduba_panel

Overview:
Front-panel request issuer for the sandwich vending FSM. It sits between the user buttons and coin slot and the FSM inputs. It synchronizes and debounces raw user inputs and forwards each request to the FSM as a single-cycle pulse, only while busy is low. It also consumes the FSM's delivery and coin-return outputs to keep saturating display counters and a sticky protocol-timeout flag.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles required before a press is accepted (>=1)
CNT_W, 8, width of each delivery/return counter
ACK_WAIT, 3, max cycles after a request pulse for busy to rise
DONE_TIMEOUT, 32, max cycles busy may stay high before timeout_err

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_green  in  1  raw green-sandwich button, asynchronous level
btn_atum  in  1  raw tuna-sandwich button, asynchronous level
btn_bacon  in  1  raw bacon-sandwich button, asynchronous level
coin_in  in  1  raw coin-slot sensor, asynchronous level
btn_dev  in  1  raw refund button, asynchronous level
busy  in  1  FSM busy (low only in ACTION)
D100  in  1  FSM coin-return strobe
GREEN, ATUM, BACON  in  1 each  FSM sandwich-delivery strobes
R_green, R_atum, R_bacon, M100, DEV  out  1 each  request pulses to FSM
erro  out  1  multi-request error pulse to FSM
pending  out  5  latched, unissued events {dev,coin,bacon,atum,green}
green_cnt, atum_cnt, bacon_cnt, coin_ret_cnt  out  CNT_W each  saturating counters
timeout_err  out  1  sticky protocol-timeout flag

Behaviour:
- Reset (async assert, sync release) sets all outputs, counters, pending, sync flops and debounce counters to 0. State becomes IDLE.
- Each raw input passes through a 2-flop synchronizer and then a debounce counter. The counter increments while the synchronized level is 1, clears on 0, and saturates at DEBOUNCE_CYCLES.
- A press event is a 1-cycle pulse on the cycle the counter reaches DEBOUNCE_CYCLES. Holding the input produces no further events; release followed by re-press produces a new event.
- Events OR into pending on the next edge. A bit already set stays set, so duplicate events merge.
- State machine (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE):
  - IDLE: if pending!=0 and busy==0, go to ISSUE.
  - ISSUE, lasting exactly one cycle:
    - Registered request outputs equal the pending bits.
    - erro=1 iff popcount(pending)>1.
    - Pending bits being issued clear. Events arriving this cycle are retained.
    - Go to WAIT_BUSY.
  - WAIT_BUSY: busy==1 goes to WAIT_DONE. If ACK_WAIT cycles pass without busy, set timeout_err and go to IDLE.
  - WAIT_DONE: busy==0 goes to IDLE. If DONE_TIMEOUT cycles pass with busy high, set timeout_err and stay in WAIT_DONE until busy falls.
- Invariants:
  - Request outputs and erro are 0 in every state except ISSUE.
  - Request outputs are never 1 on a cycle where busy==1.
  - At most one ISSUE occurs per busy episode.
- Latency: with the block in IDLE and busy low, a raw input first sampled high at edge t produces its request pulse high during cycle t+DEBOUNCE_CYCLES+3.
- Counters:
  - Rising edge of GREEN/ATUM/BACON/D100 (prev 0, now 1) increments the matching counter by 1.
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - Counters run independently of the state machine.
- timeout_err clears only on reset.
- Reset mid-operation aborts any pulse or wait immediately. No partial request is emitted after reset deasserts.

Test Plan:
- coin_in held high 10 cycles, busy low, DEBOUNCE_CYCLES=4 -> M100 high exactly 1 cycle, 7 cycles after first sampled high; erro=0; pending returns to 0.
- coin_in glitch high 3 cycles -> no event, M100 never asserted, pending stays 0.
- btn_atum and btn_dev pressed on the same cycle -> R_atum=DEV=1 together with erro=1 for one cycle.
- btn_green press while busy=1 for 20 cycles -> pending[0]=1 throughout and R_green=0. R_green pulses 1 cycle after busy falls, then the block waits for busy.
- GREEN pulsed 3 times and D100 held high 5 cycles -> green_cnt=3, coin_ret_cnt=1. With CNT_W=2 and 5 GREEN pulses -> green_cnt=3.
- Two cases, each starting from a request pulse:
  - busy never rises -> timeout_err=1 after 3 cycles, state returns to IDLE.
  - busy stays high 40 cycles -> timeout_err=1 at cycle 32. Assert reset mid-wait -> all outputs 0.
